// File: rtl/sample_player.sv
// Sample playback engine: fetches recorded samples over a request/valid read port and
// replays them on each tick at normal, fast (skip) or slow (repeat/interpolate) speed.
module sample_player (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               isNormalSpeed,
  input  logic               isFast,
  input  logic               interp,
  input  logic [2:0]         ratio,
  input  logic [19:0]        endAddr,
  output logic               rdReq,
  output logic [19:0]        rdAddr,
  input  logic [15:0]        rdData,
  input  logic               rdValid,
  output logic signed [15:0] sampleOut,
  output logic               sampleValid,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_FIN} state_t;

  state_t             state;
  logic [20:0]        p;
  logic [2:0]         j;
  logic               m_norm, m_fast, m_interp;
  logic [2:0]         m_ratio;
  logic               need_s0, need_s1;
  logic signed [15:0] s0, s1;

  logic               data_ok, slow_interp, new_si, adv;
  logic [20:0]        p_nxt;
  logic [2:0]         j_nxt;
  logic signed [15:0] play_val;

  // 2^16 / N, so that j*R[N] / 2^16 approximates j/N
  function automatic logic [16:0] recip(input logic [2:0] r);
    case (r)
      3'd0:    return 17'd65536;
      3'd1:    return 17'd32768;
      3'd2:    return 17'd21846;
      3'd3:    return 17'd16384;
      3'd4:    return 17'd13108;
      3'd5:    return 17'd10923;
      3'd6:    return 17'd9363;
      default: return 17'd8192;
    endcase
  endfunction

  function automatic logic signed [15:0] interp_sample(input logic signed [15:0] a,
                                                       input logic signed [15:0] b,
                                                       input logic [2:0] ph,
                                                       input logic [2:0] r);
    logic signed [16:0] diff;
    logic signed [39:0] prod;
    logic [16:0]        sum;
    diff = {b[15], b} - {a[15], a};
    prod = 40'(diff) * 40'($signed({1'b0, ph})) * 40'($signed({1'b0, recip(r)}));
    sum  = {a[15], a} + 17'(prod >>> 16);
    return sum[15:0];
  endfunction

  assign data_ok     = !need_s0 && !need_s1;
  assign slow_interp = !m_norm && !m_fast && m_interp;
  assign new_si      = !isNormalSpeed && !isFast && interp;
  assign play_val    = slow_interp ? interp_sample(s0, s1, j, m_ratio) : s0;

  always_comb begin
    adv   = 1'b0;
    p_nxt = p;
    j_nxt = j + 3'd1;
    if (m_norm) begin
      adv   = 1'b1;
      p_nxt = p + 21'd1;
      j_nxt = 3'd0;
    end else if (m_fast) begin
      adv   = 1'b1;
      p_nxt = p + {18'd0, m_ratio} + 21'd1;
      j_nxt = 3'd0;
    end else if (j == m_ratio) begin
      adv   = 1'b1;
      p_nxt = p + 21'd1;
      j_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      p           <= '0;
      j           <= '0;
      rdReq       <= 1'b0;
      rdAddr      <= '0;
      sampleOut   <= '0;
      sampleValid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
      need_s0     <= 1'b0;
      need_s1     <= 1'b0;
      m_norm      <= 1'b1;
      m_fast      <= 1'b0;
      m_interp    <= 1'b0;
      m_ratio     <= '0;
    end else begin
      sampleValid <= 1'b0;
      if (stop) begin
        state     <= S_IDLE;
        rdReq     <= 1'b0;
        need_s0   <= 1'b0;
        need_s1   <= 1'b0;
        sampleOut <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
      end else begin
        // read engine: one outstanding request, s0 before s1, one idle cycle between
        if (rdReq) begin
          if (rdValid) begin
            rdReq <= 1'b0;
            if (need_s0) need_s0 <= 1'b0;
            else         need_s1 <= 1'b0;
          end
        end else if (need_s0) begin
          rdReq  <= 1'b1;
          rdAddr <= p[19:0];
        end else if (need_s1) begin
          rdReq  <= 1'b1;
          rdAddr <= p[19:0] + 20'd1;
        end

        case (state)
          S_IDLE, S_FIN: begin
            if (state == S_FIN) sampleOut <= '0;
            if (start) begin
              m_norm   <= isNormalSpeed;
              m_fast   <= isFast;
              m_interp <= interp;
              m_ratio  <= ratio;
              p        <= '0;
              j        <= '0;
              need_s0  <= 1'b1;
              need_s1  <= new_si && (endAddr != 20'd0);
              underrun <= 1'b0;
              busy     <= 1'b1;
              done     <= 1'b0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: if (data_ok) state <= S_PLAY;
          S_PLAY: begin
            if (tick && !pause) begin
              sampleValid <= 1'b1;
              if (!data_ok) begin
                underrun <= 1'b1;
              end else begin
                sampleOut <= play_val;
                p         <= p_nxt;
                j         <= j_nxt;
                if (adv) begin
                  // sample boundary: the mode for the next sample is taken here
                  m_norm   <= isNormalSpeed;
                  m_fast   <= isFast;
                  m_interp <= interp;
                  m_ratio  <= ratio;
                  if (p_nxt > {1'b0, endAddr}) begin
                    state <= S_FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end else begin
                    need_s0 <= 1'b1;
                    need_s1 <= new_si && ((p_nxt + 21'd1) <= {1'b0, endAddr});
                  end
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // sample holding registers: data only, no reset
  always_ff @(posedge clk50) begin
    if (rdReq && rdValid && !stop) begin
      if (need_s0) begin
        s0 <= rdData;
        s1 <= rdData;
      end else begin
        s1 <= rdData;
      end
    end
  end

endmodule

// File: doc/sample_player.md
SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 SHALL have port clk50  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port tick  input  1  one-cycle sample strobe from the playback clock stage, clk50-synchronous.
REQ-004 SHALL have ports start, stop, pause  input  1 each  playback controls.
REQ-005 SHALL have ports isNormalSpeed, isFast, interp  input  1 each, and ratio  input  3  speed mode; factor N = ratio+1 (1..8).
REQ-006 SHALL have port endAddr  input  20  last valid recorded sample address.
REQ-007 SHALL have ports rdReq  output  1, rdAddr  output  20, rdData  input  16, rdValid  input  1  memory read handshake.
REQ-008 SHALL have ports sampleOut  output  16 (signed), sampleValid  output  1, busy  output  1, done  output  1, underrun  output  1.

Function
REQ-009 SHALL implement states IDLE, FETCH, PLAY, DONE; busy=1 in FETCH and PLAY only.
REQ-010 Read handshake SHALL hold rdReq=1 with rdAddr stable until the cycle rdValid=1; rdData is captured that cycle; rdReq drops the next cycle; rdValid with no pending request SHALL be ignored.
REQ-011 IDLE + start SHALL set read pointer p=0 and enter FETCH, latching isNormalSpeed/isFast/interp/ratio.
REQ-012 FETCH SHALL read s0=mem[p] and, if slow-interp mode, s1=mem[p+1] (s1=s0 when p+1>endAddr), then enter PLAY.
REQ-013 Mode SHALL be re-latched only at sample boundaries (phase j=0); mid-sample mode changes take effect at the next boundary.
REQ-014 Normal (isNormalSpeed=1): each tick outputs s0, advances p by 1.
REQ-015 Fast (isNormalSpeed=0, isFast=1): each tick outputs s0, advances p by N.
REQ-016 Slow (isNormalSpeed=0, isFast=0): each sample spans N ticks, phase j=0..N-1; p advances by 1 after j=N-1.
REQ-017 Slow without interp SHALL output s0 for all N ticks.
REQ-018 Slow with interp SHALL output s0 + floor(((s1-s0)*j*R[N]) / 2^16), R = 65536,32768,21846,16384,13108,10923,9363,8192 for N=1..8; difference 17-bit signed, product full width, arithmetic shift, result fits 16 bits.
REQ-019 sampleOut/sampleValid SHALL be registered: sampleValid=1 for exactly one cycle, the cycle after tick, with sampleOut valid that cycle.
REQ-020 Next sample fetch SHALL start immediately after a pointer advance (prefetch); if a tick arrives before it completes, the previous sampleOut is repeated with sampleValid=1 and underrun set (sticky until next start).
REQ-021 Pointer advance past endAddr SHALL enter DONE: done=1, sampleOut=0, no further sampleValid; start from DONE restarts at p=0.
REQ-022 pause=1 SHALL ignore ticks and freeze p, j and sampleOut; pending reads still complete.
REQ-023 stop SHALL return to IDLE next cycle from any state, drop rdReq, discard any late rdValid, sampleOut=0; stop wins over simultaneous start or tick.
REQ-024 start while busy SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, p=0, j=0, rdReq=0, rdAddr=0, sampleOut=0, sampleValid=0, busy=0, done=0, underrun=0, including mid-read; a rdValid after reset release with no request SHALL be ignored.

Verification
REQ-026 Normal, mem[0..3]=10,20,30,40, endAddr=3, 1-cycle read latency, tick every 8 cycles -> sampleOut 10,20,30,40, then done=1, underrun=0.
REQ-027 Slow interp ratio=3 (N=4), mem[0]=0, mem[1]=100 -> first four outputs 0,25,50,75, then 100.
REQ-028 Fast ratio=1 (N=2), mem[k]=k, endAddr=9 -> outputs 0,2,4,6,8, then done.
REQ-029 Read latency 20 cycles, tick every 4 cycles -> repeated sampleOut with sampleValid=1 and underrun=1.
REQ-030 stop asserted during rdReq=1 with rdValid arriving 2 cycles later -> IDLE, rdReq=0, sampleOut=0, no sampleValid.
REQ-031 pause=1 across 3 ticks mid-slow-sample -> no sampleValid, j and sampleOut unchanged; resumes at same phase after pause=0.
